snake_game_sequencer: RTL and testbench

Top-level game sequencer for the snake datapath. It steps the game through menu, stage wait, play and game over, and latches the difficulty chosen in the menu. It generates the frame and snake-move ticks, counts apples eaten, and returns to the menu after a loss. It sits between the KEY/PS2 inputs and the datapath, and replaces the bare two-state menu/game controller.

---
 rtl/snake_game_sequencer.sv | 141 ++++++++++++++
 tb/tb_snake_game_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/snake_game_sequencer.sv
// Game sequencer for the snake datapath: menu/wait/play/game-over FSM,
// difficulty latch, frame and move tick generation, and apple score.
module snake_game_sequencer #(
  parameter int FRAME_DIV       = 840000,
  parameter int GAMEOVER_FRAMES = 120,
  parameter int SCORE_W         = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               num_1,
  input  logic               num_2,
  input  logic               num_3,
  input  logic               dir_pressed,
  input  logic               esc,
  input  logic               good_collision,
  input  logic               bad_collision,
  output logic               inmenu,
  output logic               ingame,
  output logic               game_over,
  output logic               init_game,
  output logic               frame_tick,
  output logic               move_tick,
  output logic [3:0]         main_difficulty,
  output logic [SCORE_W-1:0] score
);

  localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int GW = $clog2(GAMEOVER_FRAMES + 1);
  localparam logic [FW-1:0] FRAME_RELOAD = FW'(FRAME_DIV - 1);
  localparam logic [GW-1:0] GO_MAX       = GW'(GAMEOVER_FRAMES);

  typedef enum logic [2:0] {
    S_INIT,
    S_MENU,
    S_GWAIT,
    S_INGAME,
    S_GOVER
  } state_t;

  state_t             r_state;
  logic [FW-1:0]      r_frame_cnt;
  logic [3:0]         r_move_cnt;
  logic [GW-1:0]      r_go_cnt;
  logic [3:0]         r_difficulty;
  logic [SCORE_W-1:0] r_score;
  logic               r_good_prev;
  logic               r_frame_tick;
  logic               r_move_tick;
  logic               r_init_game;
  logic               w_good_rise;

  assign w_good_rise = good_collision & ~r_good_prev;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_INIT;
      r_frame_cnt  <= FRAME_RELOAD;
      r_move_cnt   <= '0;
      r_go_cnt     <= '0;
      r_difficulty <= 4'd4;
      r_score      <= '0;
      r_good_prev  <= 1'b0;
      r_frame_tick <= 1'b0;
      r_move_tick  <= 1'b0;
      r_init_game  <= 1'b0;
    end else begin
      r_good_prev  <= good_collision;
      r_frame_tick <= 1'b0;
      r_move_tick  <= 1'b0;
      r_init_game  <= 1'b0;

      if (r_frame_cnt == '0) begin
        r_frame_cnt  <= FRAME_RELOAD;
        r_frame_tick <= 1'b1;
      end else begin
        r_frame_cnt <= r_frame_cnt - 1'b1;
      end

      case (r_state)
        S_INIT: r_state <= S_MENU;

        S_MENU: begin
          if (num_1 | num_2 | num_3) begin
            r_state     <= S_GWAIT;
            r_init_game <= 1'b1;
            r_score     <= '0;
            r_move_cnt  <= '0;
            r_go_cnt    <= '0;
            if (num_1)      r_difficulty <= 4'd4;
            else if (num_2) r_difficulty <= 4'd2;
            else            r_difficulty <= 4'd1;
          end
        end

        S_GWAIT: begin
          if (esc)              r_state <= S_MENU;
          else if (dir_pressed) r_state <= S_INGAME;
        end

        S_INGAME: begin
          if (bad_collision)    r_state <= S_GOVER;
          else if (esc)         r_state <= S_MENU;

          if (w_good_rise && !bad_collision && (r_score != '1))
            r_score <= r_score + 1'b1;

          // Suppress the step on the exit edge so no move_tick lands outside INGAME.
          if (bad_collision || esc) begin
            r_move_cnt <= '0;
          end else if (r_frame_tick) begin
            if (r_move_cnt == r_difficulty - 4'd1) begin
              r_move_cnt  <= '0;
              r_move_tick <= 1'b1;
            end else begin
              r_move_cnt <= r_move_cnt + 4'd1;
            end
          end
        end

        S_GOVER: begin
          if (r_frame_tick && (r_go_cnt != GO_MAX))
            r_go_cnt <= r_go_cnt + 1'b1;
          if (esc && (r_go_cnt == GO_MAX))
            r_state <= S_MENU;
        end

        default: r_state <= S_INIT;
      endcase
    end
  end

  assign inmenu          = (r_state == S_MENU);
  assign ingame          = (r_state == S_GWAIT) || (r_state == S_INGAME);
  assign game_over       = (r_state == S_GOVER);
  assign init_game       = r_init_game;
  assign frame_tick      = r_frame_tick;
  assign move_tick       = r_move_tick;
  assign main_difficulty = r_difficulty;
  assign score           = r_score;

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Randomized bench for snake_game_sequencer against a cycle-level game model.
module tb_snake_game_sequencer;

  localparam int FD = 10;
  localparam int GF = 3;
  localparam int SW = 2;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          num_1, num_2, num_3, dir_pressed, esc, good_collision, bad_collision;
  logic          inmenu, ingame, game_over, init_game, frame_tick, move_tick;
  logic [3:0]    main_difficulty;
  logic [SW-1:0] score;

  always #5 clk = ~clk;

  snake_game_sequencer #(
    .FRAME_DIV      (FD),
    .GAMEOVER_FRAMES(GF),
    .SCORE_W        (SW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .num_1          (num_1),
    .num_2          (num_2),
    .num_3          (num_3),
    .dir_pressed    (dir_pressed),
    .esc            (esc),
    .good_collision (good_collision),
    .bad_collision  (bad_collision),
    .inmenu         (inmenu),
    .ingame         (ingame),
    .game_over      (game_over),
    .init_game      (init_game),
    .frame_tick     (frame_tick),
    .move_tick      (move_tick),
    .main_difficulty(main_difficulty),
    .score          (score)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  // Model modes: 0 init, 1 menu, 2 wait, 3 play, 4 game over
  int m_mode, m_edges, m_frames_in_play, m_go_frames, m_diff, m_score;
  bit m_ft, m_mt, m_init, m_gprev;

  task automatic model_step();
    int nm;
    bit ft_now;
    if (!reset_n) begin
      m_mode = 0; m_edges = 0; m_frames_in_play = 0; m_go_frames = 0;
      m_diff = 4; m_score = 0; m_ft = 0; m_mt = 0; m_init = 0; m_gprev = 0;
      return;
    end
    ft_now = m_ft;
    m_edges++;
    m_ft   = (m_edges % FD) == 0;
    m_init = 0;
    m_mt   = 0;
    nm     = m_mode;
    case (m_mode)
      0: nm = 1;
      1: if (num_1 || num_2 || num_3) begin
           nm = 2; m_init = 1; m_score = 0; m_go_frames = 0; m_frames_in_play = 0;
           m_diff = num_1 ? 4 : (num_2 ? 2 : 1);
         end
      2: nm = esc ? 1 : (dir_pressed ? 3 : 2);
      3: begin
           nm = bad_collision ? 4 : (esc ? 1 : 3);
           if (good_collision && !m_gprev && !bad_collision && m_score < SMAX) m_score++;
           if (nm != 3) m_frames_in_play = 0;
           else if (ft_now) begin
             m_frames_in_play++;
             m_mt = (m_frames_in_play % m_diff) == 0;
           end
         end
      4: begin
           if (esc && m_go_frames == GF) nm = 1;
           if (ft_now && m_go_frames < GF) m_go_frames++;
         end
      default: nm = 0;
    endcase
    m_mode  = nm;
    m_gprev = good_collision;
  endtask

  task automatic compare_all();
    check("inmenu",     int'(inmenu),     int'(m_mode == 1));
    check("ingame",     int'(ingame),     int'(m_mode == 2 || m_mode == 3));
    check("game_over",  int'(game_over),  int'(m_mode == 4));
    check("init_game",  int'(init_game),  int'(m_init));
    check("frame_tick", int'(frame_tick), int'(m_ft));
    check("move_tick",  int'(move_tick),  int'(m_mt));
    check("difficulty", int'(main_difficulty), m_diff);
    check("score",      int'(score),      m_score);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    reset_n = 1'b0;
    num_1 = 0; num_2 = 0; num_3 = 0; dir_pressed = 0;
    esc = 0; good_collision = 0; bad_collision = 0;
    @(negedge clk);
    repeat (3) cycle();
    reset_n = 1'b1;
    repeat (2) cycle();

    for (int i = 0; i < 6000; i++) begin
      reset_n        = ($urandom_range(0, 799) != 0);
      num_1          = ($urandom_range(0, 19) == 0);
      num_2          = ($urandom_range(0, 19) == 0);
      num_3          = ($urandom_range(0, 19) == 0);
      dir_pressed    = ($urandom_range(0, 7) == 0);
      esc            = ($urandom_range(0, 39) == 0);
      bad_collision  = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 3) == 0) good_collision = ~good_collision;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
